// File: rtl/cpu7_exu_bypctl.sv
// ---------------------------------------------------------------------------
// cpu7_exu_bypctl
//
// Operand-bypass controller for the EXU. It follows the destination writes
// of the instructions that have left E through NUM_STG later stages. Stage 1
// (M) is the youngest. Stage NUM_STG is the last stage before the register
// file is written. For every E-stage source it then chooses where the operand
// comes from. It also holds E when a source needs a load result that is still
// in stage 1.
//
// Ports
//   i_clk        clock
//   i_reset      synchronous, active-high reset
//   i_valid_e    E stage holds a live instruction
//   i_rs_e       source addresses, source i at [i*REG_AW +: REG_AW]
//   i_rs_use_e   source i reads the register file
//   i_rd_e       E-stage destination register
//   i_wen_e      E instruction writes i_rd_e
//   i_ld_e       E instruction is a load
//   i_flush_e    kill the E instruction
//   i_pipe_hold  freeze the tracked stages and the stall counter
//   o_rs_sel     one-hot select per source: bit 0 = RF, bit k = stage k
//   o_stall_e    load-use hazard, E must hold
//   o_stall_cnt  saturating count of stall cycles
// ---------------------------------------------------------------------------
module cpu7_exu_bypctl #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int NUM_STG = 2,
  parameter int CNT_W   = 16
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_valid_e,
  input  logic [NUM_SRC*REG_AW-1:0]        i_rs_e,
  input  logic [NUM_SRC-1:0]               i_rs_use_e,
  input  logic [REG_AW-1:0]                i_rd_e,
  input  logic                             i_wen_e,
  input  logic                             i_ld_e,
  input  logic                             i_flush_e,
  input  logic                             i_pipe_hold,
  output logic [NUM_SRC*(NUM_STG+1)-1:0]   o_rs_sel,
  output logic                             o_stall_e,
  output logic [CNT_W-1:0]                 o_stall_cnt
);

  // Array index k holds stage k+1, so index 0 is the youngest stage (M).
  logic [NUM_STG-1:0]              r_vld;
  logic [NUM_STG-1:0]              r_wen;
  logic [NUM_STG-1:0]              r_ld;
  logic [NUM_STG-1:0][REG_AW-1:0]  r_rd;
  logic [CNT_W-1:0]                r_cnt;

  logic [NUM_SRC-1:0][NUM_STG-1:0] w_hit;
  logic                            w_loadUse;
  logic                            w_stg1Load;

  // A source matches a stage when that stage writes the register the source
  // reads. r0 and sources that do not read the register file never match,
  // so they always fall back to the register file.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < NUM_STG; k++) begin
        w_hit[i][k] = r_vld[k] & r_wen[k] & i_rs_use_e[i]
                    & (r_rd[k] == i_rs_e[i*REG_AW +: REG_AW])
                    & (i_rs_e[i*REG_AW +: REG_AW] != '0);
      end
    end
  end

  // Pick the youngest matching stage for each source. A load still in stage
  // 1 is reported here as well. It raises the stall, and the consumer
  // ignores the select during that cycle.
  always_comb begin
    o_rs_sel  = '0;
    w_loadUse = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      automatic logic found = 1'b0;
      for (int k = 0; k < NUM_STG; k++) begin
        if (w_hit[i][k] && !found) begin
          o_rs_sel[i*(NUM_STG+1) + k + 1] = 1'b1;
          found = 1'b1;
        end
      end
      if (!found) begin
        o_rs_sel[i*(NUM_STG+1)] = 1'b1;
      end
      w_loadUse = w_loadUse | (w_hit[i][0] & r_ld[0]);
    end
  end

  // A flush takes priority over the hazard. A stalled E instruction sends a
  // bubble into stage 1, so the load reaches stage 2 and the stall releases
  // after one cycle.
  always_comb begin
    o_stall_e  = i_valid_e & ~i_flush_e & w_loadUse;
    w_stg1Load = i_valid_e & ~i_flush_e & ~w_loadUse;
  end

  // The stages shift one step on every unheld cycle and the oldest stage
  // retires. The counter stops at its maximum instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld <= '0;
      r_wen <= '0;
      r_ld  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (!i_pipe_hold) begin
      r_vld[0] <= w_stg1Load;
      r_wen[0] <= i_wen_e;
      r_ld[0]  <= i_ld_e;
      r_rd[0]  <= i_rd_e;
      for (int k = 1; k < NUM_STG; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_wen[k] <= r_wen[k-1];
        r_ld[k]  <= r_ld[k-1];
        r_rd[k]  <= r_rd[k-1];
      end
      if (o_stall_e && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stall_cnt = r_cnt;

endmodule

// File: doc/cpu7_exu_bypctl.md
Name: cpu7_exu_bypctl

Overview:
- Parametrised EXU operand-bypass controller for NUM_SRC source operands.
- Internally tracks in-flight destination writes across NUM_STG post-execute stages: stage 1 = M, stage NUM_STG = last stage before the register-file write.
- Produces a one-hot forwarding-mux select per source and a load-use stall for the E stage.
- Keeps a saturating count of load-use stall cycles.

Parameters:
- NUM_SRC, 2, number of E-stage source operands (1..4).
- REG_AW, 5, register address width.
- NUM_STG, 2, tracked post-E stages (1..3); stage 1 is youngest.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- valid_e  in  1  E stage holds a live instruction.
- rs_e  in  NUM_SRC*REG_AW  source register addresses; source i occupies bits [i*REG_AW +: REG_AW].
- rs_use_e  in  NUM_SRC  source i reads the register file (0 = immediate/other operand).
- rd_e  in  REG_AW  E-stage destination.
- wen_e  in  1  E instruction writes rd_e.
- ld_e  in  1  E instruction is a load (result available from stage 2 onward).
- flush_e  in  1  kill the E instruction.
- pipe_hold  in  1  global freeze of the tracked stages.
- rs_sel  out  NUM_SRC*(NUM_STG+1)  per source, one-hot: bit 0 = RF, bit k = stage k.
- stall_e  out  1  load-use hazard; E must hold.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- State per stage k: vld_k, rd_k, wen_k, ld_k.
- Reset (synchronous, active-high) clears all vld_k, all ld_k and stall_cnt.
- Reset values of outputs: every rs_sel field = RF only (bit 0 set), stall_e = 0, stall_cnt = 0.
- Reset has priority over pipe_hold and flush_e; reset mid-operation discards all tracked stages.
- Stage advance, when pipe_hold = 0:
  - Stage 1 loads {1, rd_e, wen_e, ld_e} when valid_e & ~flush_e & ~stall_e; otherwise it loads a bubble (vld = 0).
  - Stage k loads stage k-1 for k >= 2; the oldest stage retires.
- pipe_hold = 1: all stage registers and stall_cnt hold. rs_sel and stall_e still evaluate combinationally from the held state.
- hit_i_k = vld_k & wen_k & (rd_k == rs_i) & rs_use_i & (rs_i != 0).
- Source select:
  - rs_sel for source i picks the lowest k with hit_i_k (youngest stage wins).
  - If there is no hit, it picks RF.
  - Exactly one bit is set per source at all times.
  - r0 and unused sources (rs_use_i = 0) always select RF.
- Load-use stall:
  - stall_e = valid_e & ~flush_e & OR over i of (hit_i_1 & ld_1).
  - A load in stage 1 is not forwardable; when NUM_STG = 1, a load hit in stage 1 stalls.
  - A load hit in any stage >= 2 forwards normally.
  - While stall_e = 1, rs_sel still reports stage 1 for the hitting source; the consumer ignores it.
- Stall releases the next unheld cycle, once the load advances to stage 2. Latency is one bubble per load-use, independent of NUM_SRC.
- flush_e and a hazard in the same cycle: flush wins. stall_e = 0 and a bubble enters stage 1.
- valid_e = 0: stall_e = 0; rs_sel is still computed and is don't-care for the consumer.
- stall_cnt increments by 1 on each unheld cycle with stall_e = 1. It saturates at 2^CNT_W - 1 and never wraps.
- Combinational paths exist only from the E inputs and state to rs_sel and stall_e; there are no combinational loops.

Test Plan:
- Reset, then idle (valid_e = 0) -> every rs_sel field = 001b (NUM_STG = 2), stall_e = 0, stall_cnt = 0.
- ALU write r5 at E, then the next cycle rs_e[0] = 5 with rs_use = 1 -> source 0 sel = 010b (stage 1). One cycle later, sel from the same writer = 100b. After it retires, sel = 001b.
- Two in-flight writes to r7 (stages 1 and 2) with rs_e[1] = 7 -> sel = 010b (youngest wins). rs = 0 or rs_use = 0 -> 001b regardless of hits.
- Load to r3 followed by a consumer reading r3 -> stall_e = 1 for exactly one cycle with a bubble in stage 1. The next cycle gives sel = 100b, stall_e = 0, stall_cnt = 1.
- Same load-use with flush_e = 1 in the hazard cycle -> stall_e = 0, stage 1 bubble, stall_cnt unchanged. With pipe_hold = 1 during the stall -> state frozen, stall_e stays 1, counter frozen.
- CNT_W = 2, five consecutive load-use stalls -> stall_cnt reads 1, 2, 3, 3, 3. Asserting reset mid-sequence -> next cycle stall_cnt = 0, all sel = RF.
